cascade_down_timer: RTL and testbench

Parametrised multi-digit down-counting timer that chains per-digit modulo counters into one timer value, for example mm:ss for the microwave controller. Each digit has its own modulus. The block adds a start/stop run FSM, clamped synchronous load, a hold-at-zero terminal condition and a one-cycle done pulse. It sits between the keypad/load logic and the display/magnetron control. It replaces per-digit standalone counters in the timer datapath.

---
 rtl/cascade_down_timer_if.sv | 9 +
 rtl/cascade_down_timer.sv | 85 ++++++++
 tb/tb_cascade_down_timer.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/cascade_down_timer_if.sv
// cascade_down_timer_if: control strobes, load data and timer status for cascade_down_timer
interface cascade_down_timer_if #(parameter int DIGITS = 4);
  logic tick, load, start, stop;
  logic [4*DIGITS-1:0] data, count;
  logic [DIGITS-1:0] tc;
  logic zero, running, done;
  modport master(output tick, load, data, start, stop, input count, tc, zero, running, done);
  modport slave(input tick, load, data, start, stop, output count, tc, zero, running, done);
endinterface

// File: rtl/cascade_down_timer.sv
// cascade_down_timer: cascaded per-digit modulo down timer with run FSM; CASCADE_TIMER_AUTORELOAD_EN reloads from the last load value at zero
module cascade_down_timer #(
  parameter int DIGITS = 4,
  parameter logic [31:0] MODS = 32'h0000_6A6A
) (
  input logic clock,
  input logic clrn,
  cascade_down_timer_if.slave bus
);
  localparam int W = 4 * DIGITS;
  typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;
  state_t state;
  logic [W-1:0] count, clamped, dec, reload_val;
  logic [DIGITS:0] low_zero;
  logic [DIGITS-1:0] dig_zero, tc;
  logic zero, running, done, auto;
  assign low_zero[0] = 1'b1;
  for (genvar i = 0; i < DIGITS; i++) begin : g_dig
    localparam logic [3:0] M = MODS[4*i+:4];
    logic [3:0] d, in_d;
    assign d = count[4*i+:4];
    assign in_d = bus.data[4*i+:4];
    assign clamped[4*i+:4] = in_d >= M ? M - 4'd1 : in_d;
    assign dig_zero[i] = d == 4'd0;
    assign low_zero[i+1] = low_zero[i] & dig_zero[i];
    // a digit only moves when every lower digit is zero, i.e. it receives the borrow
    assign dec[4*i+:4] = !low_zero[i] ? d : dig_zero[i] ? M - 4'd1 : d - 4'd1;
    // an all-zero count in RUN only happens on a reload tick, which must not borrow
    assign tc[i] = bus.tick & running & dig_zero[i] & low_zero[i] & !zero;
  end
  assign zero = low_zero[DIGITS];
`ifdef CASCADE_TIMER_AUTORELOAD_EN
  logic [W-1:0] shadow;
  // remember the clamped load value as the reload period
  always_ff @(posedge clock or negedge clrn)
    if (!clrn) shadow <= '0;
    else if (bus.load) shadow <= clamped;
  assign reload_val = shadow;
  assign auto = shadow != '0;
`else
  assign reload_val = '0;
  assign auto = 1'b0;
`endif
  // run FSM and count register, priority load > stop > start > tick
  always_ff @(posedge clock or negedge clrn) begin
    if (!clrn) begin
      count <= '0;
      state <= IDLE;
      running <= 1'b0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      if (bus.load) begin
        count <= clamped;
        state <= IDLE;
        running <= 1'b0;
      end else if (bus.stop && state == RUN) begin
        state <= IDLE;
        running <= 1'b0;
      end else if (bus.start && state == IDLE) begin
        if (!zero) begin
          state <= RUN;
          running <= 1'b1;
        end
      end else if (bus.tick && state == RUN) begin
        if (zero) count <= reload_val;
        else begin
          count <= dec;
          if (dec == '0) begin
            done <= 1'b1;
            if (!auto) begin
              state <= HALT;
              running <= 1'b0;
            end
          end
        end
      end
    end
  end
  assign bus.count = count;
  assign bus.tc = tc;
  assign bus.zero = zero;
  assign bus.running = running;
  assign bus.done = done;
endmodule

// File: tb/tb_cascade_down_timer.sv
// tb_cascade_down_timer: randomized scoreboard bench with an integer-valued reference model
module tb_cascade_down_timer;
  localparam int DIGITS = 4;
  localparam logic [31:0] MODS = 32'h0000_6A6A;
`ifdef CASCADE_TIMER_AUTORELOAD_EN
  localparam bit AR = 1'b1;
`else
  localparam bit AR = 1'b0;
`endif
  typedef struct {
    logic [15:0] count;
    logic [3:0] tc;
    logic zero, running, done;
  } exp_t;
  logic clock, clrn;
  cascade_down_timer_if #(.DIGITS(DIGITS)) bus();
  cascade_down_timer #(.DIGITS(DIGITS), .MODS(MODS)) dut(.clock(clock), .clrn(clrn), .bus(bus));
  int total = 0, bad = 0;
  exp_t q[$];
  int m[DIGITS];
  int w[DIGITS+1];
  int val, shadow, st_m;
  bit done_m;
  initial clock = 1'b0;
  always #5 clock = ~clock;
  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h t=%0t", n, a, e, $time);
    end
  endtask
  function automatic logic [15:0] to_bcd(input int v);
    logic [15:0] r = '0;
    for (int i = 0; i < DIGITS; i++) r[4*i+:4] = 4'((v / w[i]) % m[i]);
    return r;
  endfunction
  function automatic int clamp_val(input logic [15:0] d);
    int v = 0;
    for (int i = 0; i < DIGITS; i++) begin
      int dd = int'(d[4*i+:4]);
      if (dd >= m[i]) dd = m[i] - 1;
      v += dd * w[i];
    end
    return v;
  endfunction
  function automatic exp_t now_exp(input bit tk);
    exp_t e;
    e.count = to_bcd(val);
    e.zero = val == 0;
    e.running = st_m == 1;
    e.done = done_m;
    for (int i = 0; i < DIGITS; i++) e.tc[i] = tk && st_m == 1 && val != 0 && val % w[i+1] == 0;
    return e;
  endfunction
  task automatic model_step(input bit ld, input logic [15:0] d, input bit st, input bit sp, input bit tk);
    done_m = 1'b0;
    if (ld) begin
      val = clamp_val(d);
      shadow = val;
      st_m = 0;
    end else if (sp && st_m == 1) st_m = 0;
    else if (st && st_m == 0) begin
      if (val != 0) st_m = 1;
    end else if (tk && st_m == 1) begin
      if (val == 0) val = shadow;
      else begin
        val--;
        if (val == 0) begin
          done_m = 1'b1;
          if (!(AR && shadow != 0)) st_m = 2;
        end
      end
    end
  endtask
  task automatic model_reset();
    val = 0;
    shadow = 0;
    st_m = 0;
    done_m = 1'b0;
  endtask
  task automatic cyc(input bit ld, input logic [15:0] d, input bit st, input bit sp, input bit tk);
    @(negedge clock);
    bus.load = ld;
    bus.data = d;
    bus.start = st;
    bus.stop = sp;
    bus.tick = tk;
    q.push_back(now_exp(tk));
    model_step(ld, d, st, sp, tk);
  endtask
  task automatic check_reset(input string n);
    chk({n, "_count"}, 32'(bus.count), 0);
    chk({n, "_zero"}, 32'(bus.zero), 1);
    chk({n, "_running"}, 32'(bus.running), 0);
    chk({n, "_done"}, 32'(bus.done), 0);
    chk({n, "_tc"}, 32'(bus.tc), 0);
  endtask
  task automatic async_reset();
    @(negedge clock);
    {bus.load, bus.start, bus.stop, bus.tick} = '0;
    #3 clrn = 1'b0;
    #1 check_reset("midrun_reset");
    clrn = 1'b1;
    model_reset();
  endtask
  // monitor: compare the DUT against the oldest queued expectation each cycle
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      #2;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("count", 32'(bus.count), 32'(e.count));
        chk("tc", 32'(bus.tc), 32'(e.tc));
        chk("zero", 32'(bus.zero), 32'(e.zero));
        chk("running", 32'(bus.running), 32'(e.running));
        chk("done", 32'(bus.done), 32'(e.done));
      end
    end
  end
  initial begin
    logic [31:0] mv;
    logic [15:0] d;
    mv = MODS;
    w[0] = 1;
    for (int i = 0; i < DIGITS; i++) begin
      m[i] = int'(mv[4*i+:4]);
      w[i+1] = w[i] * m[i];
    end
    model_reset();
    {bus.load, bus.start, bus.stop, bus.tick} = '0;
    bus.data = '0;
    clrn = 1'b0;
    #3 check_reset("por");
    #1 clrn = 1'b1;
    cyc(1, 16'h0105, 0, 0, 0);
    cyc(0, 0, 1, 0, 0);
    for (int i = 0; i < 67; i++) cyc(0, 0, 0, 0, 1);
    cyc(1, 16'h0F9C, 0, 0, 0);
    cyc(0, 0, 1, 0, 0);
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 1);
    cyc(0, 0, 0, 1, 0);
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 1);
    cyc(0, 0, 1, 0, 0);
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 1);
    cyc(1, 16'h0000, 0, 0, 0);
    cyc(0, 0, 1, 0, 1);
    cyc(0, 0, 0, 0, 1);
    cyc(1, 16'h0042, 1, 1, 1);
    cyc(0, 0, 0, 0, 1);
    cyc(1, 16'h0003, 0, 0, 0);
    cyc(0, 0, 1, 0, 0);
    for (int i = 0; i < 11; i++) cyc(0, 0, 0, 0, 1);
    cyc(1, 16'h0230, 0, 0, 0);
    cyc(0, 0, 1, 0, 0);
    for (int i = 0; i < 5; i++) cyc(0, 0, 0, 0, 1);
    async_reset();
    for (int n = 0; n < 4000; n++) begin
      d = $urandom_range(0, 1) ? 16'($urandom_range(0, 9)) : 16'($urandom);
      cyc($urandom_range(0, 99) < 3, d, st_m != 1 && $urandom_range(0, 99) < 15,
          $urandom_range(0, 99) < 3, $urandom_range(0, 99) < 70);
      if (n % 1000 == 999) async_reset();
    end
    @(negedge clock);
    #4;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
